// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: state encoding, reset PC and instruction fields.
// Latency: none; this file holds only types, constants and a pure function.
// Backpressure: not applicable.
package cpu_pkg;

   typedef enum logic {
      FS_REQ  = 1'b0,
      FS_EXEC = 1'b1
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          INSTR_W          = 32;

   localparam int IMM_LSB     = 0;
   localparam int IMM_MSB     = 15;
   localparam int JTARGET_LSB = 0;
   localparam int JTARGET_MSB = 25;

   // Byte offset of a conditional branch: 16-bit word offset, sign-extended, times 4.
   function automatic logic [31:0] branch_offset(input logic [INSTR_W-1:0] instr);
      logic [15:0] imm;
      imm = instr[IMM_MSB:IMM_LSB];
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jr > j > taken branch > sequential, plus pc+4 for link writes.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc is consumed.
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [31:0]        pc,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               branch,
   input  logic               jump,
   input  logic               jump_reg,
   input  logic               inv_zero,
   input  logic               zero,
   input  logic [31:0]        reg_da,
   output logic [31:0]        pc_plus4,
   output logic [31:0]        next_pc,
   output logic               misaligned
);

   // Opcode bits are decoded elsewhere; they do not affect the target.
   logic unused_opcode;
   assign unused_opcode = ^instruction[INSTR_W-1:JTARGET_MSB+1];

   assign pc_plus4 = pc + 32'd4;

   // Priority select of the following PC; misalignment is reported only for jr.
   always_comb begin
      next_pc    = pc_plus4;
      misaligned = 1'b0;
      if (jump_reg) begin
         next_pc    = {reg_da[31:2], 2'b00};
         misaligned = |reg_da[1:0];
      end else if (jump) begin
         next_pc = {pc_plus4[31:28], instruction[JTARGET_MSB:JTARGET_LSB], 2'b00};
      end else if (branch && (zero ^ inv_zero)) begin
         next_pc = pc_plus4 + branch_offset(instruction);
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, fetches one word per instruction over req/ack and hands it to the decoder.
// Latency: 2 cycles per instruction with zero-wait memory; each memory wait cycle adds 1.
// Backpressure: req/addr held until ack; the PC advances only when exec_done is seen in EXEC.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ADDR_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   input  logic               exec_done,
   input  logic               branch,
   input  logic               jump,
   input  logic               jump_reg,
   input  logic               inv_zero,
   input  logic               zero,
   input  logic [ADDR_W-1:0]  reg_da,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pc_plus4,
   output logic               align_err
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic               align_q, align_d;
   logic               req_comb;

   logic [ADDR_W-1:0]  next_pc;
   logic               misaligned;

   next_pc_calc u_next_pc_calc (
      .pc          (pc_q),
      .instruction (instr_q),
      .branch      (branch),
      .jump        (jump),
      .jump_reg    (jump_reg),
      .inv_zero    (inv_zero),
      .zero        (zero),
      .reg_da      (reg_da),
      .pc_plus4    (pc_plus4),
      .next_pc     (next_pc),
      .misaligned  (misaligned)
   );

   // State and datapath registers; reset abandons any request in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FS_REQ;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         align_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         align_q <= align_d;
      end
   end

   // Next-state logic: capture the word on ack in REQ, advance the PC on exec_done in EXEC.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      align_d  = align_q;
      req_comb = 1'b0;
      case (state_q)
         FS_REQ: begin
            req_comb = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = FS_EXEC;
            end
         end
         FS_EXEC: begin
            if (exec_done) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               state_d = FS_REQ;
               if (misaligned) begin
                  align_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = FS_REQ;
         end
      endcase
   end

   // Request drops the moment reset is asserted, without waiting for a clock edge.
   assign imem_req    = req_comb & rst_n;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign align_err   = align_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        exec_done = 1'b0;
   logic        branch = 1'b0, jump = 1'b0, jump_reg = 1'b0, inv_zero = 1'b0, zero = 1'b0;
   logic [31:0] reg_da = '0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        align_err;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state
   logic [31:0] exp_pc    = 32'h0;
   logic        exp_align = 1'b0;

   instruction_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .exec_done   (exec_done),
      .branch      (branch),
      .jump        (jump),
      .jump_reg    (jump_reg),
      .inv_zero    (inv_zero),
      .zero        (zero),
      .reg_da      (reg_da),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .align_err   (align_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural next-PC rule, written with plain integer arithmetic.
   function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                            input logic br, input logic j, input logic jr,
                                            input logic iz, input logic z, input logic [31:0] da);
      longint seq;
      longint off;
      seq = (longint'(cur_pc) + 4) % 64'h1_0000_0000;
      if (jr) return da & 32'hFFFF_FFFC;
      if (j) return (seq & 64'hF000_0000) | (longint'(word & 32'h03FF_FFFF) * 4);
      if (br && (z != iz)) begin
         off = longint'($signed(word[15:0])) * 4;
         return 32'((seq + off + 64'h1_0000_0000) % 64'h1_0000_0000);
      end
      return 32'(seq);
   endfunction

   // One full fetch/execute round trip; entered and left just after a falling edge in REQ.
   task automatic run_instr(input int wait_cyc, input int exec_wait, input logic spurious,
                            input logic [31:0] word, input logic br, input logic j,
                            input logic jr, input logic iz, input logic z, input logic [31:0] da);
      for (int i = 0; i < wait_cyc; i++) begin
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, exp_pc);
         chk("wait_valid", {31'b0, instr_valid}, 32'd0);
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         @(posedge clk); @(negedge clk);
      end
      chk("req", {31'b0, imem_req}, 32'd1);
      chk("addr", imem_addr, exp_pc);
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(posedge clk); @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      chk("valid_hi", {31'b0, instr_valid}, 32'd1);
      chk("instr", instruction, word);
      chk("exec_req", {31'b0, imem_req}, 32'd0);
      chk("exec_pc", pc, exp_pc);
      for (int i = 0; i < exec_wait; i++) begin
         if (spurious) begin
            imem_ack   = 1'b1;
            imem_rdata = ~word;
         end
         @(posedge clk); @(negedge clk);
         imem_ack = 1'b0;
         chk("hold_instr", instruction, word);
         chk("hold_pc", pc, exp_pc);
         chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      end
      exec_done = 1'b1;
      branch = br; jump = j; jump_reg = jr; inv_zero = iz; zero = z; reg_da = da;
      #1;
      chk("pc_plus4", pc_plus4, 32'(longint'(exp_pc) + 4));
      @(posedge clk); @(negedge clk);
      exec_done = 1'b0;
      branch = $urandom; jump = $urandom; jump_reg = $urandom;
      inv_zero = $urandom; zero = $urandom; reg_da = $urandom;
      if (jr && (da[1:0] != 2'b00)) exp_align = 1'b1;
      exp_pc = ref_next(exp_pc, word, br, j, jr, iz, z, da);
      chk("next_pc", pc, exp_pc);
      chk("valid_lo", {31'b0, instr_valid}, 32'd0);
      chk("align_err", {31'b0, align_err}, {31'b0, exp_align});
      chk("req_again", {31'b0, imem_req}, 32'd1);
   endtask

   task automatic seq_instr();
      run_instr(0, 0, 1'b0, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic goto_pc(input logic [31:0] target);
      run_instr(0, 0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, target);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_align", {31'b0, align_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Sequential zero-wait fetch: 0, 4, 8, C
      for (int i = 0; i < 4; i++) seq_instr();
      chk("seq_pc", pc, 32'h10);

      // Memory wait of 3 cycles at 0x10, spurious acks in EXEC
      run_instr(3, 2, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // Branches around 0x20
      goto_pc(32'h20);
      run_instr(0, 0, 1'b0, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("beq_taken", pc, 32'h1C);
      goto_pc(32'h20);
      run_instr(0, 0, 1'b0, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("beq_not", pc, 32'h24);
      goto_pc(32'h20);
      run_instr(0, 0, 1'b0, 32'h1400_0004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("bne_taken", pc, 32'h34);

      // Jumps
      goto_pc(32'h9000_0000);
      run_instr(0, 0, 1'b0, 32'h0800_0040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("j_target", pc, 32'h9000_0100);
      run_instr(0, 0, 1'b0, 32'h0800_0040, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
      chk("jr_wins", pc, 32'h200);
      chk("align_clean", {31'b0, align_err}, 32'd0);
      run_instr(0, 0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h203);
      chk("jr_mis_pc", pc, 32'h200);
      seq_instr();
      seq_instr();
      chk("align_sticky", {31'b0, align_err}, 32'd1);

      // Wrap around the top of the address space
      goto_pc(32'hFFFF_FFFC);
      seq_instr();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_plus4", pc_plus4, 32'h4);

      // Reset while a request is pending at 0x40
      goto_pc(32'h40);
      chk("pre_rst_addr", imem_addr, 32'h40);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req", {31'b0, imem_req}, 32'd0);
      chk("rst_mid_pc", pc, 32'h0);
      chk("rst_mid_align", {31'b0, align_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_pc = 32'h0;
      exp_align = 1'b0;
      #1;
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_valid", {31'b0, instr_valid}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         logic [31:0] w, da;
         logic br, j, jr, iz, z;
         w  = $urandom;
         br = ($urandom_range(0, 1) == 1);
         j  = ($urandom_range(0, 4) == 0);
         jr = ($urandom_range(0, 5) == 0);
         iz = $urandom_range(0, 1) == 1;
         z  = $urandom_range(0, 1) == 1;
         da = $urandom;
         if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
         run_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1) == 1,
                   w, br, j, jr, iz, z, da);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
